// File: rtl/module_lector_7segmentos.sv
// rtl/module_lector_7segmentos.sv - debounced readback decoder for a multiplexed 7-segment display bus
module module_lector_7segmentos #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            segmentos,
    input  logic [N_DIGITS-1:0]   anodo,
    output logic [4*N_DIGITS-1:0] digitos,
    output logic [N_DIGITS-1:0]   valido,
    output logic [N_DIGITS-1:0]   error,
    output logic                  todos_validos,
    output logic                  actualizado
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int S_W   = N_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [S_W-1:0]        s_q, s_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hecho_q, hecho_d;
    logic [4*N_DIGITS-1:0] digitos_q, digitos_d;
    logic [N_DIGITS-1:0]   valido_q, valido_d;
    logic [N_DIGITS-1:0]   error_q, error_d;
    logic                  act_q, act_d;

    logic [S_W-1:0]      sample_in;
    logic [N_DIGITS-1:0] anodo_q;
    logic                anodo_onehot;
    logic                commit;
    logic [3:0]          dec_dig;
    logic                dec_val;
    logic                dec_err;

    assign sample_in    = {anodo, segmentos};
    assign anodo_q      = s_q[S_W-1:7];
    assign anodo_onehot = (anodo_q != '0) && ((anodo_q & (anodo_q - N_DIGITS'(1))) == '0);

    // Debounce: restart the run on any change, otherwise count up and commit once at the threshold
    always_comb begin
        s_d     = s_q;
        cnt_d   = cnt_q;
        hecho_d = hecho_q;
        commit  = 1'b0;
        if (sample_in != s_q) begin
            s_d     = sample_in;
            cnt_d   = CNT_ONE;
            hecho_d = 1'b0;
        end else begin
            if (cnt_q < CNT_STABLE) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if ((cnt_q == CNT_STABLE) && !hecho_q && anodo_onehot) begin
                commit  = 1'b1;
                hecho_d = 1'b1;
            end
        end
    end

    // Pattern decode of the held sample; blank reads as F, any unknown code as E with error
    always_comb begin
        dec_dig = 4'hE;
        dec_val = 1'b0;
        dec_err = 1'b1;
        case (s_q[6:0])
            7'h7E: begin dec_dig = 4'd0; dec_val = 1'b1; dec_err = 1'b0; end
            7'h30: begin dec_dig = 4'd1; dec_val = 1'b1; dec_err = 1'b0; end
            7'h6D: begin dec_dig = 4'd2; dec_val = 1'b1; dec_err = 1'b0; end
            7'h79: begin dec_dig = 4'd3; dec_val = 1'b1; dec_err = 1'b0; end
            7'h33: begin dec_dig = 4'd4; dec_val = 1'b1; dec_err = 1'b0; end
            7'h5B: begin dec_dig = 4'd5; dec_val = 1'b1; dec_err = 1'b0; end
            7'h5F: begin dec_dig = 4'd6; dec_val = 1'b1; dec_err = 1'b0; end
            7'h70: begin dec_dig = 4'd7; dec_val = 1'b1; dec_err = 1'b0; end
            7'h7F: begin dec_dig = 4'd8; dec_val = 1'b1; dec_err = 1'b0; end
            7'h73: begin dec_dig = 4'd9; dec_val = 1'b1; dec_err = 1'b0; end
            7'h00: begin dec_dig = 4'hF; dec_val = 1'b0; dec_err = 1'b0; end
            default: begin dec_dig = 4'hE; dec_val = 1'b0; dec_err = 1'b1; end
        endcase
    end

    // Slot write: only the slot selected by the held anode changes; flag a pulse if its contents differ
    always_comb begin
        digitos_d = digitos_q;
        valido_d  = valido_q;
        error_d   = error_q;
        act_d     = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (commit && anodo_q[i]) begin
                if ({digitos_q[4*i +: 4], valido_q[i], error_q[i]} != {dec_dig, dec_val, dec_err}) begin
                    act_d = 1'b1;
                end
                digitos_d[4*i +: 4] = dec_dig;
                valido_d[i]         = dec_val;
                error_d[i]          = dec_err;
            end
        end
    end

    // State registers; reset drops any partial sample and blanks every slot
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            cnt_q     <= '0;
            hecho_q   <= 1'b0;
            digitos_q <= {N_DIGITS{4'hF}};
            valido_q  <= '0;
            error_q   <= '0;
            act_q     <= 1'b0;
        end else begin
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            hecho_q   <= hecho_d;
            digitos_q <= digitos_d;
            valido_q  <= valido_d;
            error_q   <= error_d;
            act_q     <= act_d;
        end
    end

    assign digitos       = digitos_q;
    assign valido        = valido_q;
    assign error         = error_q;
    assign todos_validos = &valido_q;
    assign actualizado   = act_q;

endmodule

// File: tb/tb_module_lector_7segmentos.sv
// tb/tb_module_lector_7segmentos.sv - directed and randomized bench with a behavioural readback model
module tb_module_lector_7segmentos;

    localparam int N  = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    segmentos;
    logic [N-1:0]  anodo;
    logic [4*N-1:0] digitos;
    logic [N-1:0]  valido;
    logic [N-1:0]  error;
    logic          todos_validos;
    logic          actualizado;

    module_lector_7segmentos #(.N_DIGITS(N), .STABLE_CYCLES(SC)) dut (
        .clk           (clk),
        .rst           (rst),
        .segmentos     (segmentos),
        .anodo         (anodo),
        .digitos       (digitos),
        .valido        (valido),
        .error         (error),
        .todos_validos (todos_validos),
        .actualizado   (actualizado)
    );

    always #5 clk = ~clk;

    logic [6:0] legal [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0]  m_dig [N];
    logic        m_val [N];
    logic        m_err [N];
    logic        m_act;
    logic [10:0] m_prev;
    int          m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_dig[i] = 4'hF;
            m_val[i] = 1'b0;
            m_err[i] = 1'b0;
        end
        m_act  = 1'b0;
        m_prev = '0;
        m_run  = 0;
    endtask

    task automatic check_all();
        logic [4*N-1:0] ed;
        logic [N-1:0]   ev;
        logic [N-1:0]   ee;
        for (int i = 0; i < N; i++) begin
            ed[4*i +: 4] = m_dig[i];
            ev[i]        = m_val[i];
            ee[i]        = m_err[i];
        end
        chk("digitos", 32'(digitos), 32'(ed));
        chk("valido", 32'(valido), 32'(ev));
        chk("error", 32'(error), 32'(ee));
        chk("todos_validos", 32'(todos_validos), 32'(&ev));
        chk("actualizado", 32'(actualizado), 32'(m_act));
    endtask

    // One clock: the model sees the same inputs as the DUT edge, then outputs are compared 1 ns later
    task automatic tick();
        logic [10:0] smp;
        logic [3:0]  d;
        logic        v;
        logic        e;
        int          slot;
        smp = {anodo, segmentos};
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_act = 1'b0;
            if (smp != m_prev) begin
                m_prev = smp;
                m_run  = 1;
            end else begin
                m_run++;
            end
            if (m_run == SC + 1 && $countones(smp[10:7]) == 1) begin
                slot = 0;
                for (int i = 0; i < N; i++) if (smp[7+i]) slot = i;
                if (smp[6:0] == 7'h00) begin
                    d = 4'hF; v = 1'b0; e = 1'b0;
                end else begin
                    d = 4'hE; v = 1'b0; e = 1'b1;
                    for (int k = 0; k < 10; k++) begin
                        if (legal[k] == smp[6:0]) begin
                            d = 4'(k); v = 1'b1; e = 1'b0;
                        end
                    end
                end
                if ({m_dig[slot], m_val[slot], m_err[slot]} != {d, v, e}) m_act = 1'b1;
                m_dig[slot] = d;
                m_val[slot] = v;
                m_err[slot] = e;
            end
        end
        #1;
        check_all();
    endtask

    task automatic hold(input logic [N-1:0] an, input logic [6:0] sg, input int cycles);
        anodo     = an;
        segmentos = sg;
        for (int c = 0; c < cycles; c++) tick();
    endtask

    int pulses;

    initial begin
        model_reset();
        rst       = 1'b1;
        anodo     = '0;
        segmentos = '0;

        // Reset
        tick();
        tick();
        chk("reset_digitos", 32'(digitos), 32'h0000FFFF);
        rst = 1'b0;

        // Capture of a 3 on slot 0, then long hold without further pulse
        anodo     = 4'b0001;
        segmentos = 7'h79;
        pulses    = 0;
        for (int c = 0; c < SC + 1; c++) begin
            tick();
            if (actualizado) pulses++;
        end
        chk("capture_digit0", 32'(digitos[3:0]), 32'h3);
        chk("capture_valido0", 32'(valido[0]), 32'h1);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (actualizado) pulses++;
        end
        chk("capture_single_pulse", 32'(pulses), 32'd1);

        // Glitch: short 3 then stable 1 on slot 0 (blank first so a 3 would be visible)
        hold(4'b0001, 7'h00, 8);
        hold(4'b0001, 7'h79, 3);
        hold(4'b0001, 7'h30, 6);
        chk("glitch_digit0", 32'(digitos[3:0]), 32'h1);

        // Illegal then blank on slot 2
        hold(4'b0100, 7'h01, 6);
        chk("illegal_digit2", 32'(digitos[11:8]), 32'hE);
        chk("illegal_error2", 32'(error[2]), 32'h1);
        hold(4'b0100, 7'h00, 6);
        chk("blank_digit2", 32'(digitos[11:8]), 32'hF);
        chk("blank_error2", 32'(error[2]), 32'h0);

        // Bad anode patterns never commit
        hold(4'b0110, 7'h7E, 10);
        hold(4'b0000, 7'h7E, 10);

        // Full scan then reset mid-scan
        for (int r = 0; r < 2; r++) begin
            hold(4'b0001, 7'h30, 8);
            hold(4'b0010, 7'h6D, 8);
            hold(4'b0100, 7'h79, 8);
            hold(4'b1000, 7'h33, 8);
        end
        chk("scan_digitos", 32'(digitos), 32'h4321);
        chk("scan_todos", 32'(todos_validos), 32'h1);
        hold(4'b0001, 7'h7F, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midscan_reset", 32'(digitos), 32'h0000FFFF);
        hold(4'b0001, 7'h7F, 6);

        // Randomized runs: mixed one-hot and bad anodes, legal/blank/random patterns, varied hold lengths
        for (int s = 0; s < 80; s++) begin
            logic [N-1:0] an;
            logic [6:0]   sg;
            int           kind;
            kind = $urandom_range(0, 9);
            an = (kind < 8) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 6)      sg = legal[$urandom_range(0, 9)];
            else if (kind < 7) sg = 7'h00;
            else               sg = 7'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            hold(an, sg, $urandom_range(1, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
